hamming_encoder_engine: RTL and testbench
=========================================

# hamming_encoder_engine

Sequential Hamming(15,11)+overall-parity encoder: the transmit-side counterpart of the LSW/MSW syndrome-correction LUTs. Given a start pulse, it walks a block of 11-bit messages stored as byte pairs in data memory, computes p8/p4/p2/p1 and overall parity p0, and writes the 16-bit codewords back as byte pairs. It sits beside the processor core and masters the data-memory port while busy.

## Interface
- NUM_WORDS, 15, number of messages encoded per run (1..64)
- SRC_BASE, 0, byte address of first source message (LSW first)
- DST_BASE, 30, byte address of first codeword (LSW first)
- Clk  in  1  rising-edge clock
- Reset  in  1  reset, asynchronous, active-low
- Start  in  1  one-cycle request; honoured only in IDLE or DONE
- Busy  out  1  high while any message is being processed
- Done  out  1  high in DONE, held until next accepted Start or reset
- mem_addr  out  8  data-memory byte address
- mem_wen  out  1  write enable, one cycle per byte written
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, combinational (valid same cycle as mem_addr)

## Operation
- Source message i: LSW at SRC_BASE+2i = b8..b1; MSW at SRC_BASE+2i+1, bits[2:0] = b11..b9, bits[7:3] ignored.
- Parity: p8 = ^{b11..b5}; p4 = ^{b11,b10,b9,b8,b4,b3,b2}; p2 = ^{b11,b10,b7,b6,b4,b3,b1}; p1 = ^{b11,b9,b7,b5,b4,b2,b1}; p0 = XOR of b11..b1 and p8,p4,p2,p1.
- Codeword i: DST_BASE+2i = {b4,b3,b2,p4,b1,p2,p1,p0}; DST_BASE+2i+1 = {b11,b10,b9,b8,b7,b6,b5,p8}.
- FSM states: IDLE, RD_LSW, RD_MSW, WR_LSW, WR_MSW, DONE.
- IDLE/DONE + Start -> RD_LSW, index cleared to 0, Done cleared.
- RD_LSW: drive SRC_BASE+2i, latch mem_rdata as LSW -> RD_MSW.
- RD_MSW: drive SRC_BASE+2i+1, latch mem_rdata[2:0] -> WR_LSW.
- WR_LSW: mem_wen=1, write codeword low byte -> WR_MSW.
- WR_MSW: mem_wen=1, write codeword high byte; if i==NUM_WORDS-1 -> DONE else i++ and -> RD_LSW.
- Start while Busy is ignored.
- Addresses are 8-bit, wrap modulo 256. Overlap of source and destination ranges is the caller's problem; no checking.

## Timing
- Reset values: state IDLE, index 0, Busy 0, Done 0, mem_wen 0, mem_addr 0, mem_wdata 0. Asserting Reset mid-run forces these immediately (asynchronously); bytes already written are kept.
- Busy = 1 in RD_LSW..WR_MSW; mem_wen = 1 only in WR_LSW/WR_MSW; mem_addr and mem_wdata are 0 in IDLE/DONE.
- Exactly 4 cycles per message, no stalls. Done rises 4*NUM_WORDS+1 cycles after the edge that samples Start.
- Start in the same cycle as entering DONE is not seen (FSM not yet in DONE); Start in DONE restarts with no idle cycle.

## Configuration
- HAMMING_ENC_P0_EN defined: p0 computed as above (SECDED codeword).
- Not defined: bit 0 of every codeword LSW written as 0 (SEC only); all other bits and timing identical.

## Structure
- hamming_pkg: FSM state enum, codeword bit-position localparams (P0..P8, B1..B11 positions), NUM_WORDS default.
- One sub-module: hamming_parity (combinational, 11-bit message in, 16-bit codeword out, honours HAMMING_ENC_P0_EN); the engine owns FSM, index counter, message registers.

## Test plan
- Message 0x000 (LSW 0x00, MSW 0x00) -> codeword 0x00/0x00.
- Message 0x7FF (LSW 0xFF, MSW 0x07) -> 0xFF/0xFF.
- b1 only (LSW 0x01, MSW 0x00) -> 0x0F/0x00 with HAMMING_ENC_P0_EN; 0x0E/0x00 without.
- b11 only with junk upper MSW bits (LSW 0x00, MSW 0xFC) -> 0x17/0x81.
- Full run NUM_WORDS=15, random messages: 30 writes to 30..59 match reference model; Done at cycle 61; Start pulses mid-run ignored.
- Reset asserted in WR_LSW of message 5: outputs zero immediately, bytes for messages 0..4 intact, new Start re-encodes from message 0.

Source files
------------

// File: rtl/hamming_encoder_engine_pkg.sv
// Shared types and constants for the Hamming(15,11) encoder engine.
// Codeword bit positions follow the classic Hamming numbering, with p0 in bit 0.
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LSW,
    RD_MSW,
    WR_LSW,
    WR_MSW,
    DONE
  } state_t;

  localparam int NUM_WORDS_DEFAULT = 15;

  localparam int P0  = 0;
  localparam int P1  = 1;
  localparam int P2  = 2;
  localparam int B1  = 3;
  localparam int P4  = 4;
  localparam int B2  = 5;
  localparam int B3  = 6;
  localparam int B4  = 7;
  localparam int P8  = 8;
  localparam int B5  = 9;
  localparam int B6  = 10;
  localparam int B7  = 11;
  localparam int B8  = 12;
  localparam int B9  = 13;
  localparam int B10 = 14;
  localparam int B11 = 15;

endpackage

// File: rtl/hamming_encoder_engine_parity.sv
// Combinational Hamming(15,11) codeword builder; msg[0] is b1, msg[10] is b11.
// Overall parity p0 is produced only when HAMMING_ENC_P0_EN is defined, else bit 0 is 0.
module hamming_parity
  import hamming_pkg::*;
(
  input  logic [10:0] msg,
  output logic [15:0] codeword
);

  logic p1, p2, p4, p8;

  always_comb begin
    p8 = ^msg[10:4];
    p4 = ^{msg[10], msg[9], msg[8], msg[7], msg[3], msg[2], msg[1]};
    p2 = ^{msg[10], msg[9], msg[6], msg[5], msg[3], msg[2], msg[0]};
    p1 = ^{msg[10], msg[8], msg[6], msg[4], msg[3], msg[1], msg[0]};

    codeword      = '0;
    codeword[B1]  = msg[0];
    codeword[B2]  = msg[1];
    codeword[B3]  = msg[2];
    codeword[B4]  = msg[3];
    codeword[B5]  = msg[4];
    codeword[B6]  = msg[5];
    codeword[B7]  = msg[6];
    codeword[B8]  = msg[7];
    codeword[B9]  = msg[8];
    codeword[B10] = msg[9];
    codeword[B11] = msg[10];
    codeword[P1]  = p1;
    codeword[P2]  = p2;
    codeword[P4]  = p4;
    codeword[P8]  = p8;
`ifdef HAMMING_ENC_P0_EN
    codeword[P0]  = ^{msg, p8, p4, p2, p1};
`else
    codeword[P0]  = 1'b0;
`endif
  end

endmodule

// File: rtl/hamming_encoder_engine.sv
// Sequential block encoder: reads 11-bit messages as byte pairs, writes 16-bit codewords back.
// Overall parity bit is controlled by the HAMMING_ENC_P0_EN macro (see hamming_parity).
module hamming_encoder_engine
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEFAULT,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] mem_addr,
  output logic       mem_wen,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);
  localparam logic [7:0] SRC      = 8'(SRC_BASE);
  localparam logic [7:0] DST      = 8'(DST_BASE);

  state_t      state, state_nxt;
  logic [5:0]  idx;
  logic [7:0]  lsw;
  logic [2:0]  msw;
  logic [7:0]  offset;
  logic [15:0] codeword;
  logic        last;
  logic        unused_rdata_bits;

  assign offset            = {1'b0, idx, 1'b0};
  assign last              = (idx == LAST_IDX);
  assign unused_rdata_bits = ^mem_rdata[7:3];

  hamming_parity u_parity (
    .msg      ({msw, lsw}),
    .codeword (codeword)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx <= '0;
      lsw <= '0;
      msw <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (Start) idx <= '0;
        RD_LSW:     lsw <= mem_rdata;
        RD_MSW:     msw <= mem_rdata[2:0];
        WR_MSW:     if (!last) idx <= idx + 6'd1;
        default:    ;
      endcase
    end
  end

  // Addresses wrap naturally in 8 bits; bus outputs stay at zero when not busy.
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = RD_LSW;
      end
      RD_LSW: begin
        Busy      = 1'b1;
        mem_addr  = SRC + offset;
        state_nxt = RD_MSW;
      end
      RD_MSW: begin
        Busy      = 1'b1;
        mem_addr  = SRC + offset + 8'd1;
        state_nxt = WR_LSW;
      end
      WR_LSW: begin
        Busy      = 1'b1;
        mem_addr  = DST + offset;
        mem_wen   = 1'b1;
        mem_wdata = codeword[7:0];
        state_nxt = WR_MSW;
      end
      WR_MSW: begin
        Busy      = 1'b1;
        mem_addr  = DST + offset + 8'd1;
        mem_wen   = 1'b1;
        mem_wdata = codeword[15:8];
        state_nxt = last ? DONE : RD_LSW;
      end
      DONE: begin
        Done = 1'b1;
        if (Start) state_nxt = RD_LSW;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_encoder_engine.sv
// Directed bench for hamming_encoder_engine: hand-computed codewords plus a positional Hamming model.
// Expected bit 0 of each LSW follows HAMMING_ENC_P0_EN, matching the build of the design.
module tb_hamming_encoder_engine;

  localparam int NW  = 15;
  localparam int SRC = 0;
  localparam int DST = 30;

`ifdef HAMMING_ENC_P0_EN
  localparam logic P0_BIT = 1'b1;
`else
  localparam logic P0_BIT = 1'b0;
`endif

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic [7:0] mem_addr;
  logic       mem_wen;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] src_lsw [NW];
  logic [7:0] src_msw [NW];
  logic [7:0] exp_lsw [NW];
  logic [7:0] exp_msw [NW];

  int vector_count = 0;
  int error_count  = 0;
  int write_count  = 0;
  int bad_addr     = 0;
  int done_cyc;

  hamming_encoder_engine #(
    .NUM_WORDS (NW),
    .SRC_BASE  (SRC),
    .DST_BASE  (DST)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Busy      (Busy),
    .Done      (Done),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  assign mem_rdata = mem[mem_addr];

  always @(posedge Clk) begin
    if (mem_wen) begin
      mem[mem_addr] = mem_wdata;
      write_count++;
      if (int'(mem_addr) < DST || int'(mem_addr) > DST + 2 * NW - 1) bad_addr++;
    end
  end

  // Reference built from the positional definition: parity bit 2^k covers positions with bit k set.
  function automatic logic [15:0] ref_codeword(input logic [10:0] m);
    logic [15:0] cw;
    logic        p;
    int          d;
    cw = '0;
    d  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = m[d];
        d++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p ^= cw[pos];
      cw[1 << k] = p;
    end
`ifdef HAMMING_ENC_P0_EN
    cw[0] = ^cw[15:1];
`endif
    return cw;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vector_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus;
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  // Cycle c is the c-th cycle after the edge that sampled Start.
  task automatic waitDone(input bit mid_pulses, output int cyc);
    cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge Clk);
      if (Done) begin
        Start = 1'b0;
        cyc = c;
        break;
      end
      if (c == 3) checkOutput("busy_run", 16'(Busy), 16'd1);
      if (mid_pulses) Start = (c == 10 || c == 60);
    end
  endtask

  task automatic clearDest;
    for (int i = 0; i < 2 * NW; i++) mem[DST + i] = 8'h5A;
  endtask

  task automatic checkBlock(input int upto, input string pfx);
    for (int i = 0; i < upto; i++) begin
      checkOutput($sformatf("%s_cw%0d_lsw", pfx, i), 16'(mem[DST + 2 * i]), 16'(exp_lsw[i]));
      checkOutput($sformatf("%s_cw%0d_msw", pfx, i), 16'(mem[DST + 2 * i + 1]), 16'(exp_msw[i]));
    end
  endtask

  initial begin
    logic [15:0] cw;
    Reset = 1'b0;
    Start = 1'b0;
    {src_lsw[0],  src_msw[0]}  = 16'h0000;
    {src_lsw[1],  src_msw[1]}  = 16'hFF07;
    {src_lsw[2],  src_msw[2]}  = 16'h0100;
    {src_lsw[3],  src_msw[3]}  = 16'h00FC;
    {src_lsw[4],  src_msw[4]}  = 16'h5A03;
    {src_lsw[5],  src_msw[5]}  = 16'hC3F1;
    {src_lsw[6],  src_msw[6]}  = 16'h1206;
    {src_lsw[7],  src_msw[7]}  = 16'h8002;
    {src_lsw[8],  src_msw[8]}  = 16'h3C05;
    {src_lsw[9],  src_msw[9]}  = 16'hE718;
    {src_lsw[10], src_msw[10]} = 16'h9904;
    {src_lsw[11], src_msw[11]} = 16'h6E07;
    {src_lsw[12], src_msw[12]} = 16'h01FF;
    {src_lsw[13], src_msw[13]} = 16'hB400;
    {src_lsw[14], src_msw[14]} = 16'h7F03;
    for (int i = 0; i < 256; i++) mem[i] = 8'hC6;
    for (int i = 0; i < NW; i++) begin
      mem[SRC + 2 * i]     = src_lsw[i];
      mem[SRC + 2 * i + 1] = src_msw[i];
      cw = ref_codeword({src_msw[i][2:0], src_lsw[i]});
      exp_lsw[i] = cw[7:0];
      exp_msw[i] = cw[15:8];
    end
    clearDest();

    // Reset state
    @(negedge Clk);
    checkOutput("rst_busy",  16'(Busy),      16'd0);
    checkOutput("rst_done",  16'(Done),      16'd0);
    checkOutput("rst_wen",   16'(mem_wen),   16'd0);
    checkOutput("rst_addr",  16'(mem_addr),  16'd0);
    checkOutput("rst_wdata", 16'(mem_wdata), 16'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Full run with Start pulses while busy and one on the final WR_MSW cycle
    applyStimulus();
    waitDone(1'b1, done_cyc);
    checkOutput("done_cycle", 16'(done_cyc), 16'd61);
    @(negedge Clk);
    checkOutput("done_held", 16'(Done),     16'd1);
    checkOutput("done_busy", 16'(Busy),     16'd0);
    checkOutput("done_addr", 16'(mem_addr), 16'd0);
    checkOutput("write_count", 16'(write_count), 16'd30);
    checkOutput("bad_addr",    16'(bad_addr),    16'd0);

    // Hand-computed boundary messages
    checkOutput("zero_lsw", 16'(mem[DST + 0]), 16'h00);
    checkOutput("zero_msw", 16'(mem[DST + 1]), 16'h00);
    checkOutput("ones_lsw", 16'(mem[DST + 2]), 16'({7'h7F, P0_BIT}));
    checkOutput("ones_msw", 16'(mem[DST + 3]), 16'hFF);
    checkOutput("b1_lsw",   16'(mem[DST + 4]), 16'({7'h07, P0_BIT}));
    checkOutput("b1_msw",   16'(mem[DST + 5]), 16'h00);
    checkOutput("b11_lsw",  16'(mem[DST + 6]), 16'({7'h0B, P0_BIT}));
    checkOutput("b11_msw",  16'(mem[DST + 7]), 16'h81);
    checkBlock(NW, "run1");

    // Asynchronous reset during WR_LSW of message 5
    clearDest();
    write_count = 0;
    applyStimulus();
    for (int c = 1; c <= 23; c++) @(negedge Clk);
    checkOutput("mid_wen",  16'(mem_wen),  16'd1);
    checkOutput("mid_addr", 16'(mem_addr), 16'(DST + 10));
    Reset = 1'b0;
    #1;
    checkOutput("arst_busy",  16'(Busy),      16'd0);
    checkOutput("arst_wen",   16'(mem_wen),   16'd0);
    checkOutput("arst_addr",  16'(mem_addr),  16'd0);
    checkOutput("arst_wdata", 16'(mem_wdata), 16'd0);
    @(negedge Clk);
    checkBlock(5, "arst");
    checkOutput("arst_m5_lsw", 16'(mem[DST + 10]), 16'h5A);
    checkOutput("arst_m5_msw", 16'(mem[DST + 11]), 16'h5A);
    checkOutput("arst_writes", 16'(write_count), 16'd10);
    Reset = 1'b1;
    @(negedge Clk);

    // Fresh run from message 0 after reset
    clearDest();
    applyStimulus();
    waitDone(1'b0, done_cyc);
    checkOutput("rerun_done_cycle", 16'(done_cyc), 16'd61);
    checkBlock(NW, "rerun");

    // Start in DONE restarts with no idle cycle
    clearDest();
    applyStimulus();
    #1;
    checkOutput("restart_busy", 16'(Busy),     16'd1);
    checkOutput("restart_done", 16'(Done),     16'd0);
    checkOutput("restart_addr", 16'(mem_addr), 16'(SRC));
    waitDone(1'b0, done_cyc);
    checkOutput("restart_done_cycle", 16'(done_cyc), 16'd61);
    checkBlock(NW, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, error_count);
    $finish;
  end

endmodule
